// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizes, FSM states and layer config for the conv address sequencer
package conv_pkg;

   localparam int NUM_PE = 16;
   localparam int IFM_AW = 7;
   localparam int W_AW   = 20;
   localparam int K_W    = 8;
   localparam int P_W    = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [K_W-1:0]    num_k;
      logic [P_W-1:0]    num_pix;
      logic [IFM_AW-1:0] ifm_base;
      logic [IFM_AW-1:0] ifm_stride;
      logic [W_AW-1:0]   w_base;
      logic [NUM_PE-1:0] pe_mask;
   } cfg_t;

endpackage

// File: rtl/conv_addr_seq_if.sv
// rtl/conv_addr_seq_if.sv - layer config, stall and BRAM/PE control bundle of the sequencer
interface conv_addr_seq_if;
   import conv_pkg::*;

   logic                   start;
   logic [K_W-1:0]         cfg_num_k;
   logic [P_W-1:0]         cfg_num_pix;
   logic [IFM_AW-1:0]      cfg_ifm_base;
   logic [IFM_AW-1:0]      cfg_ifm_stride;
   logic [W_AW-1:0]        cfg_w_base;
   logic [NUM_PE-1:0]      cfg_pe_mask;
   logic                   stall;

   logic [IFM_AW-1:0]      addr;
   logic [NUM_PE*W_AW-1:0] addr_w;
   logic [NUM_PE-1:0]      PE_en;
   logic [NUM_PE-1:0]      PE_finish;
   logic [P_W-1:0]         pix_idx;
   logic                   busy;
   logic                   done;

   modport master (
      output start, cfg_num_k, cfg_num_pix, cfg_ifm_base, cfg_ifm_stride,
             cfg_w_base, cfg_pe_mask, stall,
      input  addr, addr_w, PE_en, PE_finish, pix_idx, busy, done
   );

   modport slave (
      input  start, cfg_num_k, cfg_num_pix, cfg_ifm_base, cfg_ifm_stride,
             cfg_w_base, cfg_pe_mask, stall,
      output addr, addr_w, PE_en, PE_finish, pix_idx, busy, done
   );

endinterface

// File: rtl/conv_loop_cnt.sv
// rtl/conv_loop_cnt.sv - K (inner) / P (outer) beat counters with running p*stride accumulator
module conv_loop_cnt
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic              hold,
   input  logic [K_W-1:0]    num_k,
   input  logic [P_W-1:0]    num_pix,
   input  logic [IFM_AW-1:0] stride,
   output logic [P_W-1:0]    p,
   output logic [K_W-1:0]    k_nxt,
   output logic [IFM_AW-1:0] acc_nxt,
   output logic              last_k,
   output logic              last_beat
);

   logic [K_W-1:0]    k_q, k_d;
   logic [P_W-1:0]    p_q, p_d;
   logic [IFM_AW-1:0] acc_q, acc_d;

   always_comb begin
      k_d       = k_q;
      p_d       = p_q;
      acc_d     = acc_q;
      last_k    = (k_q == num_k - K_W'(1));
      last_beat = last_k && (p_q == num_pix - P_W'(1));
      if (load) begin
         k_d   = '0;
         p_d   = '0;
         acc_d = '0;
      end else if (step && !hold) begin
         // the stride accumulator replaces a p*stride multiply
         if (last_k) begin
            k_d   = '0;
            p_d   = p_q + P_W'(1);
            acc_d = acc_q + stride;
         end else begin
            k_d = k_q + K_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k_q   <= '0;
         p_q   <= '0;
         acc_q <= '0;
      end else begin
         k_q   <= k_d;
         p_q   <= p_d;
         acc_q <= acc_d;
      end
   end

   assign p       = p_q;
   assign k_nxt   = k_d;
   assign acc_nxt = acc_d;

endmodule

// File: rtl/conv_addr_seq.sv
// rtl/conv_addr_seq.sv - layer FSM, IFM/weight read address registers and PE_en/PE_finish stage
module conv_addr_seq
   import conv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   conv_addr_seq_if.slave  bus
);

   state_e            state_q, state_d;
   cfg_t              cfg_q, cfg_d;
   logic [IFM_AW-1:0] addr_q, addr_d;
   logic [W_AW-1:0]   addr_w_q, addr_w_d;
   logic [NUM_PE-1:0] pe_en_q, pe_en_d;
   logic [NUM_PE-1:0] pe_fin_q, pe_fin_d;
   logic [P_W-1:0]    pix_q, pix_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              accept;
   logic [P_W-1:0]    cnt_p;
   logic [K_W-1:0]    k_nxt;
   logic [IFM_AW-1:0] acc_nxt;
   logic              last_k;
   logic              last_beat;

   conv_loop_cnt u_loop_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .step      (state_q == RUN),
      .hold      (bus.stall),
      .num_k     (cfg_q.num_k),
      .num_pix   (cfg_q.num_pix),
      .stride    (cfg_q.ifm_stride),
      .p         (cnt_p),
      .k_nxt     (k_nxt),
      .acc_nxt   (acc_nxt),
      .last_k    (last_k),
      .last_beat (last_beat)
   );

   always_comb begin
      state_d  = state_q;
      cfg_d    = cfg_q;
      addr_d   = addr_q;
      addr_w_d = addr_w_q;
      pe_en_d  = '0;
      pe_fin_d = '0;
      pix_d    = pix_q;
      accept   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept = 1'b1;
               cfg_d  = '{num_k:      bus.cfg_num_k,
                          num_pix:    bus.cfg_num_pix,
                          ifm_base:   bus.cfg_ifm_base,
                          ifm_stride: bus.cfg_ifm_stride,
                          w_base:     bus.cfg_w_base,
                          pe_mask:    bus.cfg_pe_mask};
               if (bus.cfg_num_k == '0 || bus.cfg_num_pix == '0) begin
                  state_d = DONE;
               end else begin
                  state_d  = RUN;
                  addr_d   = bus.cfg_ifm_base;
                  addr_w_d = bus.cfg_w_base;
               end
            end
         end
         RUN: begin
            // PE strobes lag the addresses by one cycle to match BRAM read latency
            if (!bus.stall) begin
               pe_en_d  = cfg_q.pe_mask;
               pe_fin_d = last_k ? cfg_q.pe_mask : '0;
               pix_d    = cnt_p;
               if (last_beat) begin
                  state_d = DRAIN;
               end else begin
                  addr_d   = cfg_q.ifm_base + acc_nxt + k_nxt[IFM_AW-1:0];
                  addr_w_d = cfg_q.w_base + W_AW'(k_nxt);
               end
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cfg_q    <= '0;
         addr_q   <= '0;
         addr_w_q <= '0;
         pe_en_q  <= '0;
         pe_fin_q <= '0;
         pix_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cfg_q    <= cfg_d;
         addr_q   <= addr_d;
         addr_w_q <= addr_w_d;
         pe_en_q  <= pe_en_d;
         pe_fin_q <= pe_fin_d;
         pix_q    <= pix_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // weight BRAMs are per-PE but read the same word index, so one register feeds all slices
   assign bus.addr      = addr_q;
   assign bus.addr_w    = {NUM_PE{addr_w_q}};
   assign bus.PE_en     = pe_en_q;
   assign bus.PE_finish = pe_fin_q;
   assign bus.pix_idx   = pix_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_addr_seq.sv
// tb/tb_conv_addr_seq.sv - scoreboard bench for conv_addr_seq with a per-beat reference model
module tb_conv_addr_seq;
   import conv_pkg::*;

   typedef struct {
      logic [IFM_AW-1:0] addr;
      logic [W_AW-1:0]   aw;
      logic [NUM_PE-1:0] en;
      logic [NUM_PE-1:0] fin;
      logic [P_W-1:0]    pix;
   } beat_t;

   logic clk;
   logic reset;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   beat_t exp_q[$];
   int    done_q[$];
   bit    pre_pat[$];

   logic [IFM_AW-1:0]      prev_addr;
   logic [NUM_PE*W_AW-1:0] prev_aw;

   conv_addr_seq_if bus ();

   conv_addr_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor: every PE_en beat and every done pulse is matched against the scoreboard
   always @(negedge clk) begin : monitor
      beat_t b;
      if (bus.PE_en != '0) begin
         if (exp_q.size() == 0) begin
            chk("extra_pe_en", 64'(bus.PE_en), 64'd0);
         end else begin
            b = exp_q.pop_front();
            chk("pe_en", 64'(bus.PE_en), 64'(b.en));
            chk("pe_finish", 64'(bus.PE_finish), 64'(b.fin));
            chk("pix_idx", 64'(bus.pix_idx), 64'(b.pix));
            chk("addr", 64'(prev_addr), 64'(b.addr));
            for (int i = 0; i < NUM_PE; i++)
               chk("addr_w_slice", 64'(prev_aw[i*W_AW +: W_AW]), 64'(b.aw));
         end
      end else if (bus.PE_finish != '0) begin
         chk("stray_finish", 64'(bus.PE_finish), 64'd0);
      end
      if (bus.done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done", 64'(bus.done), 64'd0);
         end else begin
            chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
            chk("busy_at_done", 64'(bus.busy), 64'd0);
         end
      end
      prev_addr = bus.addr;
      prev_aw   = bus.addr_w;
   end

   task automatic set_cfg(input int nk, input int np, input int base, input int stride,
                          input int wb, input int mask);
      bus.cfg_num_k      = K_W'(nk);
      bus.cfg_num_pix    = P_W'(np);
      bus.cfg_ifm_base   = IFM_AW'(base);
      bus.cfg_ifm_stride = IFM_AW'(stride);
      bus.cfg_w_base     = W_AW'(wb);
      bus.cfg_pe_mask    = NUM_PE'(mask);
   endtask

   task automatic scramble_cfg();
      set_cfg($urandom_range(255), $urandom_range(1023), $urandom_range(127),
              $urandom_range(127), $urandom_range(20'hFFFFF), $urandom_range(16'hFFFF));
   endtask

   task automatic push_beats(input int nk, input int np, input int base, input int stride,
                             input int wb, input int mask);
      beat_t b;
      for (int p = 0; p < np; p++) begin
         for (int k = 0; k < nk; k++) begin
            b.addr = IFM_AW'((base + p * stride + k) % (1 << IFM_AW));
            b.aw   = W_AW'((wb + k) % (1 << W_AW));
            b.en   = NUM_PE'(mask);
            b.fin  = (k == nk - 1) ? NUM_PE'(mask) : '0;
            b.pix  = P_W'(p);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_addr"},      64'(bus.addr), 64'd0);
      chk({tag, "_addr_w"},    64'(bus.addr_w == '0), 64'd1);
      chk({tag, "_pe_en"},     64'(bus.PE_en), 64'd0);
      chk({tag, "_pe_finish"}, 64'(bus.PE_finish), 64'd0);
      chk({tag, "_pix_idx"},   64'(bus.pix_idx), 64'd0);
      chk({tag, "_busy"},      64'(bus.busy), 64'd0);
      chk({tag, "_done"},      64'(bus.done), 64'd0);
   endtask

   task automatic run_layer(input int nk, input int np, input int base, input int stride,
                            input int wb, input int mask, input int pct, input bit dup);
      bit pat[$];
      bit s;
      int zeros;
      int c;
      int n;
      bit live;
      live = (nk != 0) && (np != 0);
      if (pre_pat.size() != 0) begin
         pat = pre_pat;
         pre_pat.delete();
      end else begin
         zeros = 0;
         while (zeros < nk * np) begin
            s = ($urandom_range(99) < pct);
            pat.push_back(s);
            if (!s) zeros++;
         end
      end
      @(negedge clk);
      c = cyc;
      push_beats(nk, np, base, stride, wb, mask);
      done_q.push_back(live ? c + 2 + pat.size() : c + 1);
      set_cfg(nk, np, base, stride, wb, mask);
      bus.start = 1'b1;
      bus.stall = 1'($urandom_range(1));
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_start", 64'(bus.busy), 64'(live));
      if (live) chk("addr_first", 64'(bus.addr), 64'(base % (1 << IFM_AW)));
      foreach (pat[i]) begin
         bus.stall = pat[i];
         bus.start = dup && (i == 0);
         scramble_cfg();
         @(negedge clk);
      end
      bus.stall = 1'($urandom_range(1));
      bus.start = dup;
      scramble_cfg();
      @(negedge clk);
      bus.start = 1'b0;
      bus.stall = 1'b0;
      n = 0;
      while (done_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (done_q.size() != 0) begin
         chk("done_timeout", 64'(done_q.size()), 64'd0);
         done_q.delete();
      end
      @(negedge clk);
      chk("beats_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      chk("busy_idle", 64'(bus.busy), 64'd0);
      chk("done_low", 64'(bus.done), 64'd0);
   endtask

   initial begin
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      reset = 1'b1;
      @(negedge clk);

      run_layer(4, 2, 10, 4, 'h100, 'hFFFF, 0, 1'b0);
      run_layer(2, 1, 33, 7, 'h5, 'h000F, 0, 1'b0);
      pre_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      run_layer(4, 1, 50, 9, 'h20, 'hFFFF, 0, 1'b0);
      run_layer(4, 1, 126, 3, 'hFFFFE, 'h8001, 0, 1'b0);
      run_layer(0, 5, 12, 1, 'h40, 'hFFFF, 0, 1'b1);
      run_layer(3, 0, 12, 1, 'h40, 'hFFFF, 0, 1'b0);
      run_layer(3, 2, 100, 20, 'h77, 'hA5A5, 0, 1'b1);

      // asynchronous reset in the middle of a K=8 run, then a clean rerun
      @(negedge clk);
      push_beats(8, 1, 5, 2, 'h300, 'hFFFF);
      set_cfg(8, 1, 5, 2, 'h300, 'hFFFF);
      bus.start = 1'b1;
      bus.stall = 1'b0;
      repeat (4) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #2 reset = 1'b0;
      #1 check_reset_outputs("mid_run_reset");
      exp_q.delete();
      done_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run_layer(8, 1, 5, 2, 'h300, 'hFFFF, 0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         run_layer($urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(127),
                   $urandom_range(127),
                   ($urandom_range(1) == 1) ? 'hFFFFD : $urandom_range(20'hFFFFF),
                   $urandom_range(1, 16'hFFFF), 30, 1'($urandom_range(1)));
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

endmodule
